divide_sequencer: RTL and testbench

Multi-cycle 32-bit restoring divider controller. It sequences a single instance of the team's combinational `subtractor` over 32 trial-subtraction iterations to produce quotient and remainder, signed or unsigned. It sits beside the ALU as the DIV execution unit and is driven by the control unit through a start/done handshake. Its results are intended for the HI (remainder) and LO (quotient) registers.

---
 rtl/divide_sequencer.sv | 144 ++++++++++++++
 tb/tb_divide_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/divide_sequencer.sv
// Multi-cycle 32-bit restoring divider (signed or unsigned) sequencing one shared
// combinational subtractor over 32 trial-subtraction iterations; start/done handshake.

module subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  assign {borrow, difference} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

module divide_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic             op_signed;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] q_shift;
  logic [4:0]       count;
  logic             neg_q;
  logic             neg_r;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] trial;
  logic             carry;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             accept;

  // Magnitudes; negating 0x80000000 yields itself, read as unsigned 2^31.
  assign dvd_neg = op_signed & dvd_reg[WIDTH-1];
  assign dvs_neg = op_signed & dvs_reg[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dvd_reg : dvd_reg;
  assign dvs_mag = dvs_neg ? -dvs_reg : dvs_reg;

  // The bit shifted out of R acts as a 33rd bit: when set, S exceeds any divisor.
  assign trial  = {part_rem[WIDTH-2:0], q_shift[WIDTH-1]};
  assign carry  = part_rem[WIDTH-1];
  assign accept = carry | ~borrow;

  subtractor #(.WIDTH(WIDTH)) u_sub (
    .minuend    (trial),
    .subtrahend (d_mag),
    .difference (diff),
    .borrow     (borrow)
  );

  assign busy = (state == PREP) || (state == ITER) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_signed   <= 1'b0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      d_mag       <= '0;
      part_rem    <= '0;
      q_shift     <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_reg     <= dividend;
              dvs_reg     <= divisor;
              op_signed   <= signed_op;
              div_by_zero <= 1'b0;
              state       <= PREP;
            end
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          d_mag    <= dvs_mag;
          q_shift  <= dvd_mag;
          part_rem <= '0;
          neg_q    <= dvd_neg ^ dvs_neg;
          neg_r    <= dvd_neg;
          count    <= 5'd31;
          state    <= ITER;
        end
        ITER: begin
          part_rem <= accept ? diff : trial;
          q_shift  <= {q_shift[WIDTH-2:0], accept};
          if (count == 5'd0) begin
            state <= FIX;
          end else begin
            count <= count - 5'd1;
          end
        end
        FIX: begin
          quotient  <= neg_q ? -q_shift : q_shift;
          remainder <= neg_r ? -part_rem : part_rem;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_sequencer.sv
// Scoreboard bench for divide_sequencer: stimulus pushes model results, a monitor
// pops and compares them (values, latency, busy duration) whenever done is seen.

module tb_divide_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  divide_sequencer #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: truncating division straight from the arithmetic definition.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   m;
    longint sa;
    longint sb_v;
    m.issue = 0;
    if (b == 32'd0) begin
      m.q = 32'hFFFF_FFFF;
      m.r = a;
      m.dbz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb_v = longint'($signed(b));
      m.q = 32'(sa / sb_v);
      m.r = 32'(sa % sb_v);
      m.dbz = 1'b0;
    end else begin
      m.q = a / b;
      m.r = a % b;
      m.dbz = 1'b0;
    end
    return m;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " quotient"}, quotient, 32'd0);
    check_output({tag, " remainder"}, remainder, 32'd0);
    check_output({tag, " div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    check_output({tag, " busy"}, {31'd0, busy}, 32'd0);
    check_output({tag, " done"}, {31'd0, done}, 32'd0);
  endtask

  // Called at a negedge; drives start for exactly one edge, then scrambles inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    e = model(a, b, s);
    e.issue = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    issue(a, b, s);
    wait_idle();
  endtask

  // Monitor: compares every done against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected done: got done=1 expected no result pending");
          end else begin
            e = sb.pop_front();
            check_output("quotient", quotient, e.q);
            check_output("remainder", remainder, e.r);
            check_output("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            check_output("latency", 32'(cyc - e.issue), e.dbz ? 32'd0 : 32'd34);
            check_output("busy cycles", 32'(busy_cnt), e.dbz ? 32'd0 : 32'd34);
            check_output("busy at done", {31'd0, busy}, 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          n;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] directed cases");
    apply_stimulus(32'd100, 32'd7, 1'b0);
    apply_stimulus(32'hFFFF_FF9C, 32'd7, 1'b1);
    apply_stimulus(32'd100, 32'hFFFF_FFF9, 1'b1);
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
    apply_stimulus(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    apply_stimulus(32'h0000_1234, 32'd0, 1'b0);
    apply_stimulus(32'h0000_1234, 32'd0, 1'b1);
    apply_stimulus(32'd50, 32'd5, 1'b0);

    $display("[TB] start ignored mid-iteration");
    issue(32'd1000, 32'd33, 1'b0);
    repeat (10) @(negedge clock);
    dividend = 32'd77;
    divisor = 32'd4;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    $display("[TB] back-to-back via start in DONE");
    issue(32'd12345, 32'd67, 1'b0);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clock);
      n++;
    end
    issue(32'hFFFF_F000, 32'd16, 1'b1);
    wait_idle();

    $display("[TB] reset mid-iteration");
    issue(32'd999, 32'd10, 1'b0);
    repeat (18) @(negedge clock);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check_reset_outputs("mid-op reset");
    repeat (3) @(negedge clock);
    check_reset_outputs("reset held");
    reset_n = 1'b1;
    @(negedge clock);
    apply_stimulus(32'd9, 32'd3, 1'b0);

    $display("[TB] random cases");
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'h8000_0000;
        3:       b = 32'hFFFF_FFFF;
        4:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      apply_stimulus(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
